// File: rtl/sys_defs.sv
// Shared types and constants for the vectorised ExpMul stage of the attention datapath.
package sys_defs;
  localparam int SCORE_W_DEF     = 16;
  localparam int SCORE_FRAC_DEF  = 8;
  localparam int V_W_DEF         = 16;
  localparam int EXPMUL_LANES    = 4;
  // log2(e) ~= 1 + 1/2 - 1/16
  localparam int LOG2E_ADD_SHIFT = 1;
  localparam int LOG2E_SUB_SHIFT = 4;

  typedef logic signed [SCORE_W_DEF-1:0] SCORE_QT;
  typedef logic signed [V_W_DEF-1:0]     EXPMUL_VSHIFT_QT;
endpackage

// File: rtl/expmul_scale_split.sv
// Turns a max-relative score difference into an integer shift n and a fraction f
// for the base-2 exponent approximation 2^-(n+f) ~= (1 - f/2) >> n.
module expmul_scale_split
  import sys_defs::*;
#(
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int SCORE_FRAC = SCORE_FRAC_DEF
) (
  input  logic [SCORE_W-1:0]            a_i,
  input  logic [SCORE_W-1:0]            b_i,
  output logic [SCORE_W+1-SCORE_FRAC:0] n_o,
  output logic [SCORE_FRAC-1:0]         f_o
);

  logic signed [SCORE_W:0]   d_s;
  logic signed [SCORE_W+1:0] dc_s;
  logic signed [SCORE_W+1:0] x_s;
  logic signed [SCORE_W+1:0] t_s;

  // Difference, clamp to <= 0 so the exponent never exceeds 1, then scale by log2(e).
  always_comb begin
    d_s = $signed({a_i[SCORE_W-1], a_i}) - $signed({b_i[SCORE_W-1], b_i});
    if (d_s[SCORE_W] == 1'b0) begin
      dc_s = '0;
    end else begin
      dc_s = {d_s[SCORE_W], d_s};
    end
    x_s = dc_s + (dc_s >>> LOG2E_ADD_SHIFT) - (dc_s >>> LOG2E_SUB_SHIFT);
    t_s = -x_s;
  end

  assign n_o = t_s[SCORE_W+1:SCORE_FRAC];
  assign f_o = t_s[SCORE_FRAC-1:0];

endmodule

// File: rtl/expmul_vec.sv
// Three-stage elastic ExpMul pipeline: rescales a V slice by exp(s-m) and an O slice
// by exp(m_prev-m), LANES elements per transaction.
module expmul_vec
  import sys_defs::*;
#(
  parameter int LANES      = EXPMUL_LANES,
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int SCORE_FRAC = SCORE_FRAC_DEF,
  parameter int V_W        = V_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_in,
  output logic                   rdy_out,
  output logic                   vld_out,
  input  logic                   rdy_in,
  input  logic                   first_in,
  input  logic [SCORE_W-1:0]     m_in,
  input  logic [SCORE_W-1:0]     m_prev_in,
  input  logic [SCORE_W-1:0]     s_in,
  input  logic [LANES*V_W-1:0]   v_star_in,
  input  logic [LANES*V_W-1:0]   o_star_prev_in,
  output logic [LANES*V_W-1:0]   exp_v_out,
  output logic [LANES*V_W-1:0]   exp_o_out
);

  localparam int NW = SCORE_W + 2 - SCORE_FRAC;
  localparam int PW = V_W + SCORE_FRAC + 1;

  logic en1_s, en2_s, en3_s;
  logic vld1_q, vld2_q, vld3_q;
  logic first1_q, first2_q;

  logic [NW-1:0]         n_v_d, n_o_d, n_v1_q, n_o1_q, n_v2_q, n_o2_q;
  logic [SCORE_FRAC-1:0] f_v_d, f_o_d, f_v1_q, f_o1_q;

  logic [LANES-1:0][V_W-1:0] v1_q, o1_q, v2_q, o2_q;
  logic [LANES-1:0][PW-1:0]  pv_d, po_d, pv2_q, po2_q;
  logic [LANES-1:0][V_W-1:0] ev_d, eo_d, exp_v_q, exp_o_q;

  // Ready ripples backwards: a stage may load when empty or when its successor loads.
  assign en3_s   = !vld3_q || rdy_in;
  assign en2_s   = !vld2_q || en3_s;
  assign en1_s   = !vld1_q || en2_s;
  assign rdy_out = en1_s;

  expmul_scale_split #(.SCORE_W(SCORE_W), .SCORE_FRAC(SCORE_FRAC)) u_split_v (
    .a_i (s_in),
    .b_i (m_in),
    .n_o (n_v_d),
    .f_o (f_v_d)
  );

  expmul_scale_split #(.SCORE_W(SCORE_W), .SCORE_FRAC(SCORE_FRAC)) u_split_o (
    .a_i (m_prev_in),
    .b_i (m_in),
    .n_o (n_o_d),
    .f_o (f_o_d)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [PW-1:0] v1e_s, o1e_s, v2e_s, o2e_s, dv_s, do_s;

    assign v1e_s = PW'($signed(v1_q[l]));
    assign o1e_s = PW'($signed(o1_q[l]));
    assign v2e_s = PW'($signed(v2_q[l]));
    assign o2e_s = PW'($signed(o2_q[l]));

    assign pv_d[l] = v1e_s * $signed({{(PW-SCORE_FRAC){1'b0}}, f_v1_q});
    assign po_d[l] = o1e_s * $signed({{(PW-SCORE_FRAC){1'b0}}, f_o1_q});

    // elem*(1 - f/2) then >> n; shifts past the element width would leave -1, not 0.
    assign dv_s = v2e_s - ($signed(pv2_q[l]) >>> (SCORE_FRAC + 1));
    assign do_s = o2e_s - ($signed(po2_q[l]) >>> (SCORE_FRAC + 1));

    assign ev_d[l] = (n_v2_q >= NW'(V_W)) ? '0 : V_W'(dv_s >>> n_v2_q);
    assign eo_d[l] = (first2_q || (n_o2_q >= NW'(V_W))) ? '0 : V_W'(do_s >>> n_o2_q);
  end

  // Pipeline registers with per-stage enables and synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      vld3_q   <= 1'b0;
      first1_q <= 1'b0;
      first2_q <= 1'b0;
      n_v1_q   <= '0;
      n_o1_q   <= '0;
      f_v1_q   <= '0;
      f_o1_q   <= '0;
      n_v2_q   <= '0;
      n_o2_q   <= '0;
      v1_q     <= '0;
      o1_q     <= '0;
      v2_q     <= '0;
      o2_q     <= '0;
      pv2_q    <= '0;
      po2_q    <= '0;
      exp_v_q  <= '0;
      exp_o_q  <= '0;
    end else begin
      if (en1_s) begin
        vld1_q <= vld_in;
        if (vld_in) begin
          first1_q <= first_in;
          n_v1_q   <= n_v_d;
          n_o1_q   <= n_o_d;
          f_v1_q   <= f_v_d;
          f_o1_q   <= f_o_d;
          v1_q     <= v_star_in;
          o1_q     <= o_star_prev_in;
        end
      end
      if (en2_s) begin
        vld2_q <= vld1_q;
        if (vld1_q) begin
          first2_q <= first1_q;
          n_v2_q   <= n_v1_q;
          n_o2_q   <= n_o1_q;
          v2_q     <= v1_q;
          o2_q     <= o1_q;
          pv2_q    <= pv_d;
          po2_q    <= po_d;
        end
      end
      if (en3_s) begin
        vld3_q <= vld2_q;
        if (vld2_q) begin
          exp_v_q <= ev_d;
          exp_o_q <= eo_d;
        end
      end
    end
  end

  assign vld_out   = vld3_q;
  assign exp_v_out = exp_v_q;
  assign exp_o_out = exp_o_q;

endmodule
